multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle MIPS control sequencer driving the shared datapath: one ALU, one unified instruction/data memory port, one register-file write port. Walks each instruction through fetch, decode, execute, memory and writeback states and emits per-cycle datapath controls. Stalls on a ready handshake with memory. Counts retired instructions for the processor bench.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- opcode  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0] from instruction register
- zero  in  1  ALU zero flag (current cycle)
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (valid with mem_req)
- iord  out  1  0 = address from PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = reg B, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- alu_ctrl  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- illegal  out  1  one-cycle pulse on undecodable instruction
- retired  out  CNT_W  instructions completed (saturating)
- state  out  4  current state, for debug

## Operation
- Supported: R-type (opcode 0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- States and transitions:
  - IDLE → FETCH.
  - FETCH: mem_req, iord=0, alu PC+4 (src_a 0, src_b 1, ADD). While mem_ready=0, hold state with ir_write, pc_write at 0. On mem_ready=1, pulse ir_write and pc_write (pc_src 0) → DECODE.
  - DECODE: ALU computes PC+(imm<<2) (src_a 0, src_b 3, ADD) into ALUOut. Branch by opcode: lw/sw → MEMADR; R-type → RTYPE_EX; addi → ADDI_EX; beq → BRANCH; j → JUMP. Other opcode, or R-type with unlisted funct → illegal=1, → FETCH.
  - MEMADR: src_a 1, src_b 2, ADD. lw → MEMRD; sw → MEMWR.
  - MEMRD: mem_req, iord=1. Hold until mem_ready, then → MEMWB.
  - MEMWR: mem_req, mem_we, iord=1. Hold until mem_ready, then retire → FETCH.
  - MEMWB: reg_write, reg_dst 0, mem_to_reg 1. Retire → FETCH.
  - RTYPE_EX: src_a 1, src_b 0, alu_ctrl from funct → RTYPE_WB.
  - RTYPE_WB: reg_write, reg_dst 1, mem_to_reg 0. Retire → FETCH.
  - ADDI_EX: src_a 1, src_b 2, ADD → ADDI_WB.
  - ADDI_WB: reg_write, reg_dst 0, mem_to_reg 0. Retire → FETCH.
  - BRANCH: src_a 1, src_b 0, SUB, pc_write_cond, pc_src 1. Retire → FETCH.
  - JUMP: pc_write, pc_src 2. Retire → FETCH.
- Outputs are a Moore function of state, plus mem_ready for the FETCH pulses. Any output not listed for a state is 0.
- retired increments by 1 on each retiring transition and saturates at all-ones. Illegal instructions do not retire.

## Timing
- With mem_ready tied high, cycles per instruction: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. mem_req stays asserted and all address/control outputs stay stable until the ready cycle.
- Reset (rst=0), applied asynchronously at any point including mid-access: state=IDLE, retired=0, all outputs 0. The first FETCH is the cycle after rst deasserts.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- Shared include mips_defs.vh holds opcode and funct constants, alu_ctrl codes, and state encodings. The processor datapath reuses it.
- One sub-module, alu_decoder: combinational funct → alu_ctrl plus funct-valid flag, instantiated inside the FSM.

## Test plan
- Reset, then add (0x00/0x20) with mem_ready=1 → states FETCH, DECODE, RTYPE_EX, RTYPE_WB; reg_write=1, reg_dst=1 in cycle 4; retired=1.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total; mem_req held, iord=1 throughout MEMRD; mem_to_reg=1 in MEMWB.
- beq, then j → 3 cycles each; pc_write_cond=1, alu_ctrl=1 in BRANCH; pc_write=1, pc_src=2 in JUMP; retired=2.
- Opcode 0x3F, then R-type funct 0x00 → illegal pulses once in each DECODE, next state FETCH, retired unchanged.
- rst driven low mid-MEMWR with mem_we=1 → mem_req, mem_we and retired go 0 immediately without waiting for clk; IDLE, then FETCH after release.
- Run 7-instruction sequence add, addi, add, add, sub, and, or with mem_ready=1 → retired=7 after 28 cycles.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared MIPS definitions for the multi-cycle controller and the processor
// datapath: opcode/funct values, ALU operation codes, datapath mux selects,
// sequencer state encoding and the per-state control word.
// No ports (package).
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // Instruction opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWR    = 4'd5,
        S_MEMWB    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    // Moore part of the datapath controls, registered alongside the state
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    // Controls held throughout a state. The FETCH ir_write/pc_write pulses
    // depend on mem_ready and are formed outside this table.
    function automatic ctrl_t state_ctrl(state_t s, logic [2:0] rtype_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_ctrl  = ALU_ADD;
                c.pc_src    = PC_SRC_ALU;
            end
            S_DECODE:   c.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_RTYPE_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_ctrl  = rtype_alu;
            end
            S_RTYPE_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB:  c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_ctrl      = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_SRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the control sequencer and the datapath.
//   master : the sequencer (takes IR fields, zero, mem_ready; drives controls)
//   slave  : the datapath / memory side
// Handshake: mem_req is held with stable iord/mem_we until a cycle in which
// mem_ready is 1; that cycle completes the access. mem_ready is only looked at
// while a request is outstanding.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst,
               mem_to_reg, illegal, retired, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst,
               mem_to_reg, illegal, retired, state
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_alu_decoder
// Combinational R-type funct decode.
//   i_funct    : instruction[5:0]
//   o_alu_ctrl : ALU operation for the funct (ADD when unknown)
//   o_valid    : funct is one of the supported R-type operations
// -----------------------------------------------------------------------------
module multicycle_ctrl_alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_valid
);
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_valid    = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_ctrl = ALU_ADD;
            FN_SUB:  o_alu_ctrl = ALU_SUB;
            FN_AND:  o_alu_ctrl = ALU_AND;
            FN_OR:   o_alu_ctrl = ALU_OR;
            FN_SLT:  o_alu_ctrl = ALU_SLT;
            default: o_valid    = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle MIPS control sequencer for a shared ALU / unified memory /
// single register-write-port datapath.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : multicycle_ctrl_if.master (IR fields, zero, mem_ready in;
//         datapath controls, illegal pulse, retired count, debug state out)
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_fetch;
    logic             w_funct_ok;
    logic [2:0]       w_rtype_alu;
    logic             w_unused_zero;

    // zero is consumed by the datapath through pc_write_cond
    assign w_unused_zero = bus.zero;

    multicycle_ctrl_alu_decoder u_alu_dec (
        .i_funct    (bus.funct),
        .o_alu_ctrl (w_rtype_alu),
        .o_valid    (w_funct_ok)
    );

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = w_funct_ok ? S_RTYPE_EX : S_FETCH;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_RTYPE_EX: w_next = S_RTYPE_WB;
            S_ADDI_EX:  w_next = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Controls are registered for the state being entered, so they are
    // valid from the first cycle of that state and stay stable while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ctrl    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next, w_rtype_alu);
            if (w_retire && (r_retired != '1)) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign w_fetch = (r_state == S_FETCH);

    assign bus.mem_req       = r_ctrl.mem_req;
    assign bus.mem_we        = r_ctrl.mem_we;
    assign bus.iord          = r_ctrl.iord;
    assign bus.ir_write      = w_fetch & bus.mem_ready;
    assign bus.pc_write      = r_ctrl.pc_write | (w_fetch & bus.mem_ready);
    assign bus.pc_write_cond = r_ctrl.pc_write_cond;
    assign bus.pc_src        = r_ctrl.pc_src;
    assign bus.alu_src_a     = r_ctrl.alu_src_a;
    assign bus.alu_src_b     = r_ctrl.alu_src_b;
    assign bus.alu_ctrl      = r_ctrl.alu_ctrl;
    assign bus.reg_write     = r_ctrl.reg_write;
    assign bus.reg_dst       = r_ctrl.reg_dst;
    assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
    // An undecodable instruction is exactly a DECODE that falls back to FETCH
    assign bus.illegal       = (r_state == S_DECODE) && (w_next == S_FETCH);
    assign bus.retired       = r_retired;
    assign bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed and random instruction streams. The driver expands each
// instruction into its per-cycle expected control word and queues it; the
// monitor pops one entry for every non-IDLE cycle of the DUT and compares.
// A second instance with a 3-bit counter checks retired saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int OBS_W = 54;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();
    multicycle_ctrl_if #(.CNT_W(3))  bus_s ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_ctrl #(.CNT_W(3)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.opcode    = bus.opcode;
    assign bus_s.funct     = bus.funct;
    assign bus_s.zero      = bus.zero;
    assign bus_s.mem_ready = bus.mem_ready;

    // ---------------- scoreboard state ----------------
    int               total = 0;
    int               bad   = 0;
    int               model_retired = 0;
    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] act_word;
    logic [OBS_W-1:0] mon_exp;

    assign act_word = {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write,
                       bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.alu_src_a,
                       bus.alu_src_b, bus.alu_ctrl, bus.reg_write, bus.reg_dst,
                       bus.mem_to_reg, bus.illegal, bus.retired};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            6'h2A:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs for one cycle, straight from the per-state rules
    function automatic logic [OBS_W-1:0] ref_word(input state_t st, input logic mr,
                                                  input logic [5:0] fn, input logic ill,
                                                  input logic [31:0] ret);
        logic       req = 0, we = 0, iord = 0, irw = 0, pcw = 0, pcwc = 0;
        logic [1:0] pcs = 0, srcb = 0;
        logic       srca = 0, rw = 0, rdst = 0, m2r = 0;
        logic [2:0] alu = 0;
        case (st)
            S_FETCH:    begin req = 1; srcb = 1; irw = mr; pcw = mr; end
            S_DECODE:   srcb = 3;
            S_MEMADR:   begin srca = 1; srcb = 2; end
            S_MEMRD:    begin req = 1; iord = 1; end
            S_MEMWR:    begin req = 1; we = 1; iord = 1; end
            S_MEMWB:    begin rw = 1; m2r = 1; end
            S_RTYPE_EX: begin srca = 1; alu = ref_alu(fn); end
            S_RTYPE_WB: begin rw = 1; rdst = 1; end
            S_ADDI_EX:  begin srca = 1; srcb = 2; end
            S_ADDI_WB:  rw = 1;
            S_BRANCH:   begin srca = 1; alu = 1; pcwc = 1; pcs = 1; end
            S_JUMP:     begin pcw = 1; pcs = 2; end
            default:    ;
        endcase
        return {st, req, we, iord, irw, pcw, pcwc, pcs, srca, srcb, alu,
                rw, rdst, m2r, ill, ret};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input state_t st, input logic mr, input logic ill);
        bus.mem_ready = mr;
        bus.zero      = 1'($urandom_range(0, 1));
        exp_q.push_back(ref_word(st, mr, bus.funct, ill, 32'(model_retired)));
        @(posedge clk);
        #1;
    endtask

    // mem_ready is irrelevant in these states, so it is randomised
    task automatic rstep(input state_t st);
        step(st, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int sf, input int sm);
        logic legal;
        bus.opcode = op;
        bus.funct  = fn;
        legal = (op == 6'h00) ? (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
                              : (op inside {6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
        repeat (sf) step(S_FETCH, 1'b0, 1'b0);
        step(S_FETCH, 1'b1, 1'b0);
        step(S_DECODE, 1'($urandom_range(0, 1)), !legal);
        if (legal) begin
            case (op)
                6'h23: begin
                    rstep(S_MEMADR);
                    repeat (sm) step(S_MEMRD, 1'b0, 1'b0);
                    step(S_MEMRD, 1'b1, 1'b0);
                    rstep(S_MEMWB);
                end
                6'h2B: begin
                    rstep(S_MEMADR);
                    repeat (sm) step(S_MEMWR, 1'b0, 1'b0);
                    step(S_MEMWR, 1'b1, 1'b0);
                end
                6'h00: begin rstep(S_RTYPE_EX); rstep(S_RTYPE_WB); end
                6'h08: begin rstep(S_ADDI_EX);  rstep(S_ADDI_WB);  end
                6'h04: rstep(S_BRANCH);
                default: rstep(S_JUMP);
            endcase
            model_retired++;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst && (bus.state != S_IDLE)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cycle: got state %0d expected no activity at %0t",
                         bus.state, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("cycle_trace", 64'(act_word), 64'(mon_exp));
                chk("retired_sat", 64'(bus_s.retired),
                    (mon_exp[31:0] > 32'd7) ? 64'd7 : 64'(mon_exp[2:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [5:0] seq_op [7] = '{6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] seq_fn [7] = '{6'h20, 6'h11, 6'h20, 6'h20, 6'h22, 6'h24, 6'h25};
    logic [5:0] r_fns  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_word", 64'(act_word), 64'd0);
        chk("reset_sat_retired", 64'(bus_s.retired), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("first_fetch", 64'(bus.state), 64'(S_FETCH));

        // add, lw with stalls, beq, j
        run_instr(6'h00, 6'h20, 0, 0);
        chk("add_retired", 64'(bus.retired), 64'd1);
        run_instr(6'h23, 6'h00, 2, 3);
        run_instr(6'h04, 6'h00, 0, 0);
        run_instr(6'h02, 6'h00, 0, 0);
        chk("beq_j_retired", 64'(bus.retired), 64'(model_retired));

        // undecodable opcode and R-type funct
        run_instr(6'h3F, 6'h20, 0, 0);
        run_instr(6'h00, 6'h00, 1, 0);
        chk("illegal_no_retire", 64'(bus.retired), 64'd4);

        // asynchronous reset in the middle of a store
        bus.opcode = 6'h2B;
        bus.funct  = 6'h15;
        step(S_FETCH, 1'b1, 1'b0);
        rstep(S_DECODE);
        rstep(S_MEMADR);
        bus.mem_ready = 1'b0;
        exp_q.push_back(ref_word(S_MEMWR, 1'b0, bus.funct, 1'b0, 32'(model_retired)));
        @(negedge clk);
        #2;
        chk("memwr_we_before_reset", 64'(bus.mem_we), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("async_rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("async_rst_retired", 64'(bus.retired), 64'd0);
        chk("async_rst_state", 64'(bus.state), 64'(S_IDLE));
        model_retired = 0;
        @(posedge clk);
        #1;
        chk("reset_hold_idle", 64'(bus.state), 64'(S_IDLE));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("fetch_after_release", 64'(bus.state), 64'(S_FETCH));

        // seven back-to-back single-cycle-memory instructions
        for (int i = 0; i < 7; i++) run_instr(seq_op[i], seq_fn[i], 0, 0);
        chk("seq7_retired", 64'(bus.retired), 64'd7);

        // random stream
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = r_fns[$urandom_range(0, 4)]; end
                1: begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
                2: begin op = 6'h08; fn = 6'($urandom_range(0, 63)); end
                3: begin op = 6'h23; fn = 6'($urandom_range(0, 63)); end
                4: begin op = 6'h2B; fn = 6'($urandom_range(0, 63)); end
                5: begin op = 6'h04; fn = 6'($urandom_range(0, 63)); end
                6: begin op = 6'h02; fn = 6'($urandom_range(0, 63)); end
                default: begin op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
            endcase
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        chk("final_retired", 64'(bus.retired), 64'(model_retired));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
